// File: rtl/controle_telas.sv
// Screen-sequencing controller: game-level FSM, animation toggle and
// frame-aligned RGB selection for the VGA output.
module controle_telas #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int TROCA_FRAMES = 30,
    parameter int END_FRAMES   = 180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  h_counter,
    input  logic [9:0]  v_counter,
    input  logic        btn_start,
    input  logic        vitoria,
    input  logic        derrota,
    input  logic [23:0] rgb_inicial,
    input  logic [23:0] rgb_jogo,
    input  logic [23:0] rgb_vitoria,
    input  logic [23:0] rgb_derrota,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic [1:0]  tela,
    output logic        jogo_ativo,
    output logic        troca,
    output logic        frame_tick
);

    localparam int EW = $clog2(END_FRAMES + 1);
    localparam int TW = $clog2(TROCA_FRAMES + 1);
    localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

    typedef enum logic [1:0] {
        INICIAL = 2'd0,
        JOGO    = 2'd1,
        VITORIA = 2'd2,
        DERROTA = 2'd3
    } tela_t;

    tela_t         r_tela;
    tela_t         r_req_tgt;
    logic          r_req_v;
    logic          r_cond_q;
    logic          r_btn_q;
    logic          r_frame_tick;
    logic          r_troca;
    logic          r_jogo_ativo;
    logic [EW-1:0] r_end_cnt;
    logic [TW-1:0] r_troca_cnt;
    logic [23:0]   r_rgb;

    logic          w_cond;
    logic          w_start_rise;
    logic          w_ev_v;
    tela_t         w_ev_tgt;
    tela_t         w_tela_nxt;
    logic          w_visible;
    logic [23:0]   w_rgb;

    assign w_cond       = (h_counter == 10'd0) && (v_counter == V_LIM);
    assign w_start_rise = btn_start && !r_btn_q;
    assign w_visible    = (h_counter < H_LIM) && (v_counter < V_LIM);

    always_comb begin
        w_ev_v   = 1'b0;
        w_ev_tgt = INICIAL;
        unique case (r_tela)
            INICIAL: begin
                w_ev_v   = w_start_rise;
                w_ev_tgt = JOGO;
            end
            JOGO: begin
                // Defeat outranks victory when both arrive together
                w_ev_v   = derrota || vitoria;
                w_ev_tgt = derrota ? DERROTA : VITORIA;
            end
            default: begin
                w_ev_v   = w_start_rise || (r_frame_tick &&
                           (r_end_cnt == EW'(END_FRAMES - 1)));
                w_ev_tgt = INICIAL;
            end
        endcase
    end

    always_comb begin
        w_tela_nxt = r_tela;
        if (r_frame_tick) begin
            if (w_ev_v)
                w_tela_nxt = w_ev_tgt;
            else if (r_req_v)
                w_tela_nxt = r_req_tgt;
        end
    end

    always_comb begin
        unique case (r_tela)
            INICIAL: w_rgb = rgb_inicial;
            JOGO:    w_rgb = rgb_jogo;
            VITORIA: w_rgb = rgb_vitoria;
            default: w_rgb = rgb_derrota;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tela       <= INICIAL;
            r_req_v      <= 1'b0;
            r_req_tgt    <= INICIAL;
            r_cond_q     <= 1'b0;
            r_btn_q      <= 1'b0;
            r_frame_tick <= 1'b0;
            r_troca      <= 1'b0;
            r_jogo_ativo <= 1'b0;
            r_end_cnt    <= '0;
            r_troca_cnt  <= '0;
            r_rgb        <= '0;
        end else begin
            r_cond_q     <= w_cond;
            r_btn_q      <= btn_start;
            r_frame_tick <= w_cond && !r_cond_q;
            r_tela       <= w_tela_nxt;
            r_jogo_ativo <= (w_tela_nxt == JOGO);
            r_rgb        <= w_visible ? w_rgb : 24'h0;

            if (r_frame_tick) begin
                r_req_v <= 1'b0;
            end else if (w_ev_v) begin
                r_req_v   <= 1'b1;
                r_req_tgt <= w_ev_tgt;
            end

            if (w_tela_nxt != r_tela)
                r_end_cnt <= '0;
            else if (r_frame_tick && r_tela[1] &&
                     r_end_cnt != EW'(END_FRAMES))
                r_end_cnt <= r_end_cnt + 1'b1;

            if (r_frame_tick) begin
                if (r_troca_cnt == TW'(TROCA_FRAMES - 1)) begin
                    r_troca_cnt <= '0;
                    r_troca     <= ~r_troca;
                end else begin
                    r_troca_cnt <= r_troca_cnt + 1'b1;
                end
            end
        end
    end

    assign tela       = r_tela;
    assign jogo_ativo = r_jogo_ativo;
    assign troca      = r_troca;
    assign frame_tick = r_frame_tick;
    assign R          = r_rgb[23:16];
    assign G          = r_rgb[15:8];
    assign B          = r_rgb[7:0];

endmodule

// File: tb/tb_controle_telas.sv
// Directed bench for controle_telas: screen flow, frame tick,
// troca toggle, end-screen timeout and colour blanking.
module tb_controle_telas;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  h_counter, v_counter;
    logic        btn_start, vitoria, derrota;
    logic [23:0] rgb_inicial, rgb_jogo, rgb_vitoria, rgb_derrota;
    logic [7:0]  R, G, B;
    logic [1:0]  tela;
    logic        jogo_ativo, troca, frame_tick;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    controle_telas #(
        .H_ACTIVE(640), .V_ACTIVE(480),
        .TROCA_FRAMES(30), .END_FRAMES(180)
    ) dut (
        .clk(clk), .reset(reset),
        .h_counter(h_counter), .v_counter(v_counter),
        .btn_start(btn_start), .vitoria(vitoria), .derrota(derrota),
        .rgb_inicial(rgb_inicial), .rgb_jogo(rgb_jogo),
        .rgb_vitoria(rgb_vitoria), .rgb_derrota(rgb_derrota),
        .R(R), .G(G), .B(B), .tela(tela), .jogo_ativo(jogo_ativo),
        .troca(troca), .frame_tick(frame_tick)
    );

    // Stimulus: one short frame, boundary reached then left
    task automatic frame();
        @(negedge clk); h_counter = 10'd0; v_counter = 10'd480;
        @(negedge clk); h_counter = 10'd1; v_counter = 10'd480;
        @(negedge clk); h_counter = 10'd1; v_counter = 10'd100;
    endtask

    task automatic btn_pulse();
        @(negedge clk); btn_start = 1'b1;
        @(negedge clk); btn_start = 1'b0;
    endtask

    task automatic vit_pulse();
        @(negedge clk); vitoria = 1'b1;
        @(negedge clk); vitoria = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; btn_start = 1'b0; vitoria = 1'b0; derrota = 1'b0;
        h_counter = 10'd1; v_counter = 10'd100;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({tela, jogo_ativo, troca, frame_tick} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got tela=%0d ja=%b tr=%b ft=%b want 0",
                     tela, jogo_ativo, troca, frame_tick);
        end
        n_cmp++;
        if ({R, G, B} !== 24'h0) begin
            n_err++;
            $display("FAIL reset_rgb got %h want 000000", {R, G, B});
        end
    endtask

    task automatic test_frame_tick();
        int highs = 0;
        @(negedge clk); h_counter = 10'd0; v_counter = 10'd480;
        @(negedge clk);
        n_cmp++;
        if (frame_tick !== 1'b1) begin
            n_err++;
            $display("FAIL tick_first got %b want 1", frame_tick);
        end
        highs = frame_tick ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (frame_tick) highs++;
        end
        h_counter = 10'd1; v_counter = 10'd100;
        @(negedge clk);
        if (frame_tick) highs++;
        n_cmp++;
        if (highs !== 1) begin
            n_err++;
            $display("FAIL tick_width got %0d cycles want 1", highs);
        end
    endtask

    task automatic test_troca();
        apply_reset();
        for (int n = 1; n <= 120; n++) begin
            frame();
            n_cmp++;
            if (troca !== 1'((n / 30) % 2)) begin
                n_err++;
                $display("FAIL troca_tick%0d got %b want %b",
                         n, troca, 1'((n / 30) % 2));
            end
        end
    endtask

    task automatic test_start_hold();
        @(negedge clk); h_counter = 10'd50; v_counter = 10'd100;
        btn_start = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (tela !== 2'd0) begin
            n_err++;
            $display("FAIL start_pending got tela=%0d want 0", tela);
        end
        frame();
        n_cmp++;
        if (tela !== 2'd1 || jogo_ativo !== 1'b1) begin
            n_err++;
            $display("FAIL start_go got tela=%0d ja=%b want 1/1",
                     tela, jogo_ativo);
        end
        frame();
        frame();
        n_cmp++;
        if (tela !== 2'd1) begin
            n_err++;
            $display("FAIL start_held got tela=%0d want 1", tela);
        end
        btn_start = 1'b0;
    endtask

    task automatic test_both_pulse();
        @(negedge clk); vitoria = 1'b1; derrota = 1'b1;
        @(negedge clk); vitoria = 1'b0; derrota = 1'b0;
        n_cmp++;
        if (tela !== 2'd1) begin
            n_err++;
            $display("FAIL both_wait got tela=%0d want 1", tela);
        end
        frame();
        n_cmp++;
        if (tela !== 2'd3 || jogo_ativo !== 1'b0) begin
            n_err++;
            $display("FAIL both_derrota got tela=%0d ja=%b want 3/0",
                     tela, jogo_ativo);
        end
        rgb_inicial = 24'h111111; rgb_jogo = 24'h222222;
        rgb_vitoria = 24'h333333; rgb_derrota = 24'hFF0000;
        h_counter = 10'd10; v_counter = 10'd10;
        @(negedge clk);
        n_cmp++;
        if ({R, G, B} !== 24'hFF0000) begin
            n_err++;
            $display("FAIL derrota_rgb got %h want ff0000", {R, G, B});
        end
    endtask

    task automatic test_colour_blank();
        rgb_inicial = 24'hFFFFFF; rgb_jogo = 24'hFFFFFF;
        rgb_vitoria = 24'hFFFFFF; rgb_derrota = 24'hFFFFFF;
        h_counter = 10'd650; v_counter = 10'd10;
        @(negedge clk);
        n_cmp++;
        if ({R, G, B} !== 24'h0) begin
            n_err++;
            $display("FAIL blank_h got %h want 000000", {R, G, B});
        end
        h_counter = 10'd10; v_counter = 10'd490;
        @(negedge clk);
        n_cmp++;
        if ({R, G, B} !== 24'h0) begin
            n_err++;
            $display("FAIL blank_v got %h want 000000", {R, G, B});
        end
        h_counter = 10'd639; v_counter = 10'd479;
        #1;
        n_cmp++;
        if ({R, G, B} !== 24'h0) begin
            n_err++;
            $display("FAIL latency got %h want 000000", {R, G, B});
        end
        @(negedge clk);
        n_cmp++;
        if ({R, G, B} !== 24'hFFFFFF) begin
            n_err++;
            $display("FAIL edge_pixel got %h want ffffff", {R, G, B});
        end
        h_counter = 10'd1; v_counter = 10'd100;
    endtask

    task automatic test_timeout();
        btn_pulse();
        frame();
        n_cmp++;
        if (tela !== 2'd0) begin
            n_err++;
            $display("FAIL end_start got tela=%0d want 0", tela);
        end
        btn_pulse(); frame();
        vit_pulse(); frame();
        n_cmp++;
        if (tela !== 2'd2) begin
            n_err++;
            $display("FAIL vitoria_go got tela=%0d want 2", tela);
        end
        for (int n = 0; n < 179; n++) frame();
        n_cmp++;
        if (tela !== 2'd2) begin
            n_err++;
            $display("FAIL timeout_179 got tela=%0d want 2", tela);
        end
        frame();
        n_cmp++;
        if (tela !== 2'd0) begin
            n_err++;
            $display("FAIL timeout_180 got tela=%0d want 0", tela);
        end
    endtask

    task automatic test_start_abort();
        btn_pulse(); frame();
        vit_pulse(); frame();
        for (int n = 0; n < 10; n++) frame();
        btn_pulse();
        n_cmp++;
        if (tela !== 2'd2) begin
            n_err++;
            $display("FAIL abort_wait got tela=%0d want 2", tela);
        end
        frame();
        n_cmp++;
        if (tela !== 2'd0) begin
            n_err++;
            $display("FAIL abort_tick11 got tela=%0d want 0", tela);
        end
    endtask

    task automatic test_reset_mid();
        btn_pulse(); frame();
        vit_pulse(); frame();
        @(negedge clk); h_counter = 10'd200; v_counter = 10'd200;
        @(negedge clk);
        btn_pulse();
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({tela, jogo_ativo, troca, frame_tick, R, G, B} !== 29'h0) begin
            n_err++;
            $display("FAIL reset_mid got tela=%0d ja=%b tr=%b rgb=%h want 0",
                     tela, jogo_ativo, troca, {R, G, B});
        end
        @(negedge clk); reset = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            frame();
            if (n == 1) begin
                n_cmp++;
                if (tela !== 2'd0) begin
                    n_err++;
                    $display("FAIL req_lost got tela=%0d want 0", tela);
                end
            end
            n_cmp++;
            if (troca !== (n == 30)) begin
                n_err++;
                $display("FAIL troca_restart%0d got %b want %b",
                         n, troca, (n == 30));
            end
        end
    endtask

    initial begin
        reset = 1'b1; btn_start = 1'b0; vitoria = 1'b0; derrota = 1'b0;
        h_counter = 10'd1; v_counter = 10'd100;
        rgb_inicial = '0; rgb_jogo = '0; rgb_vitoria = '0; rgb_derrota = '0;
        test_reset();
        test_frame_tick();
        test_troca();
        test_start_hold();
        test_both_pulse();
        test_colour_blank();
        test_timeout();
        test_start_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/controle_telas.md
# controle_telas

Screen-sequencing controller for the VGA game. It owns the game-level state machine (title, play, victory, defeat) and switches screens only at frame boundaries, so the change never lands mid-frame and causes tearing. It generates the `troca` animation toggle consumed by the sprite blocks. It also muxes the four screen compositors' RGB streams onto the single VGA colour output. Sits between the VGA timing counters / screen compositors and the VGA output driver.

## Interface
- `H_ACTIVE`, 640, visible pixels per line.
- `V_ACTIVE`, 480, visible lines per frame.
- `TROCA_FRAMES`, 30, frames per half-period of `troca`; must be ≥1.
- `END_FRAMES`, 180, frames the victory/defeat screen stays up before returning to title; must be ≥1.
- `clk`  in  1  system clock; the one clock.
- `reset`  in  1  asynchronous, active-high reset.
- `h_counter`  in  10  current pixel column from the VGA timing block.
- `v_counter`  in  10  current line from the VGA timing block.
- `btn_start`  in  1  start button, already synchronised, level, active-high.
- `vitoria`  in  1  one-cycle pulse from game logic: player won.
- `derrota`  in  1  one-cycle pulse from game logic: player lost.
- `rgb_inicial`, `rgb_jogo`, `rgb_vitoria`, `rgb_derrota`  in  24 each  `{R,G,B}` from each screen compositor.
- `R`, `G`, `B`  out  8 each  registered colour to VGA.
- `tela`  out  2  current screen: 0 INICIAL, 1 JOGO, 2 VITORIA, 3 DERROTA.
- `jogo_ativo`  out  1  high while `tela`==JOGO; enables game logic.
- `troca`  out  1  animation phase toggle.
- `frame_tick`  out  1  one-cycle pulse at each frame boundary.

## Operation
- Frame boundary condition: `h_counter`==0 && `v_counter`==`V_ACTIVE`, i.e. the start of vertical blank.
  - `frame_tick` = condition && !condition_q, using a registered copy of the condition.
  - It is therefore exactly one `clk` wide, even when the counters hold for several clocks.
- Start edge: `start_rise` = `btn_start` && !`btn_start_q`. Holding the button produces only one event.
- Request register `req` (valid + 2-bit target). It is loaded on qualifying events:
  - INICIAL: `start_rise` → JOGO.
  - JOGO: `derrota` → DERROTA; `vitoria` → VITORIA. If both pulse in the same cycle, DERROTA wins.
  - VITORIA/DERROTA: `start_rise` → INICIAL. Also `end_cnt`==`END_FRAMES`-1 on a `frame_tick` → INICIAL.
  - A later event overwrites the pending target; priority inside a cycle is as listed.
  - Events that do not qualify in the current state are ignored.
- On `frame_tick`: if `req` is valid, or an event is qualifying in that same cycle, `tela` takes the target and `req` clears. Otherwise `tela` holds.
- `end_cnt` (width clog2(`END_FRAMES`+1)):
  - clears on every `tela` change;
  - increments on `frame_tick` only while in VITORIA/DERROTA;
  - saturates at `END_FRAMES`.
- `troca_cnt` (width clog2(`TROCA_FRAMES`+1)):
  - counts `frame_tick`s, free-running in all states;
  - at `TROCA_FRAMES`-1 on a tick it wraps to 0 and `troca` inverts.
- Colour mux: selects the input matching `tela`.
  - Forced to 0 when `h_counter`≥`H_ACTIVE` or `v_counter`≥`V_ACTIVE`.
  - Registered into `R`/`G`/`B`.
- `jogo_ativo` is registered and equals (`tela`==JOGO).

## Timing
- Reset values: `tela`=0 (INICIAL), `R`/`G`/`B`=0, `jogo_ativo`=0, `troca`=0, `frame_tick`=0, all counters 0, `req` invalid, edge-detect flops 0.
- Reset asserted mid-frame or mid-request: everything returns to the reset values immediately (asynchronous). Any pending request is lost.
- Colour latency: 1 `clk` from `h_counter`/`v_counter`/`rgb_*` to `R`/`G`/`B`.
- `frame_tick`: registered; high in the cycle after the counters first meet the boundary condition.
- Screen change: `tela` and `jogo_ativo` update in the cycle after the `frame_tick` pulse.
  - Worst-case event-to-change latency is one full frame plus 2 cycles.
- End-screen timeout: `tela` returns to INICIAL after exactly `END_FRAMES` `frame_tick`s spent in VITORIA/DERROTA.

## Test plan
- Reset mid-frame while `tela`=2 → next cycle all outputs 0, `tela`=0; counters restart from 0.
- INICIAL, `btn_start` rises at line 100 and is held high for 3 frames → exactly one transition: `tela`=1 one cycle after the next `frame_tick`; `jogo_ativo`=1; no further change.
- JOGO, `vitoria` and `derrota` pulse in the same cycle → at the next tick `tela`=3; `rgb_derrota`=24'hFF0000 appears as R=FF G=00 B=00 on visible pixels.
- `tela`=2, no input → after exactly 180 ticks `tela`=0. Repeat with `btn_start` rising at tick 10 → `tela`=0 at tick 11.
- TROCA_FRAMES=30, 120 frames → `troca` toggles at ticks 30, 60, 90 and 120, and is 0 after tick 120.
- `rgb_*` all 24'hFFFFFF, `h_counter`=650 or `v_counter`=490 → `R`/`G`/`B`=0 one cycle later. `h_counter`=639, `v_counter`=479 → FF.
